// File: rtl/game_state_ctrl.sv
// Game-flow master: MENU/PLAY/WON/LOST, jump timer, obstacle hits,
// lives and score for the counter_shapes / VGA renderer pair.
module game_state_ctrl #(
  parameter logic [10:0] WIN_TIME    = 11'd1800,
  parameter int          LIVES       = 3,
  parameter logic [9:0]  OBJ_START   = 10'd680,
  parameter logic [9:0]  PLAYER_X_LO = 10'd80,
  parameter logic [9:0]  PLAYER_X_HI = 10'd120,
  parameter logic [7:0]  JUMP_LEN    = 8'd40,
  parameter logic [7:0]  END_HOLD    = 8'd120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        jump_btn,
  input  logic [9:0]  obj_position_counter,
  input  logic [10:0] game_time,
  output logic        menuScreen,
  output logic        playerWon,
  output logic        playerLost,
  output logic        reset_obj_count,
  output logic        hit,
  output logic        airborne,
  output logic [2:0]  lives,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {
    S_MENU,
    S_PLAY,
    S_WON,
    S_LOST
  } state_t;

  state_t     state, state_nx;
  logic       start_q, jump_q;
  logic       start_rise, jump_rise;
  logic [7:0] jtmr, jtmr_nx;
  logic [7:0] htmr, htmr_nx;
  logic       air_nx;
  logic [2:0] lives_nx;
  logic [7:0] score_nx;
  logic       hit_nx;
  logic [9:0] obj_x;
  logic       in_win, hit_cond, clear, win;

  assign start_rise = start_btn & ~start_q;
  assign jump_rise  = jump_btn & ~jump_q;

  // Obstacle already past the origin wraps obj_x, so gate on the raw counter
  assign obj_x  = OBJ_START - obj_position_counter;
  assign in_win = (obj_position_counter <= OBJ_START) &&
                  (obj_x >= PLAYER_X_LO) &&
                  (obj_x <= PLAYER_X_HI);

  assign hit_cond = (state == S_PLAY) && !airborne &&
                    in_win && !reset_obj_count;
  assign clear    = obj_position_counter >= OBJ_START;
  assign win      = game_time >= WIN_TIME;

  always_comb begin
    state_nx = state;
    jtmr_nx  = jtmr;
    htmr_nx  = htmr;
    air_nx   = airborne;
    lives_nx = lives;
    score_nx = score;
    hit_nx   = 1'b0;
    unique case (state)
      S_MENU: begin
        if (start_rise) begin
          state_nx = S_PLAY;
          lives_nx = 3'(LIVES);
          score_nx = 8'd0;
          air_nx   = 1'b0;
          jtmr_nx  = 8'd0;
        end
      end
      S_PLAY: begin
        hit_nx = hit_cond;
        if (airborne) begin
          if (jtmr == 8'd0) air_nx = 1'b0;
          else jtmr_nx = jtmr - 8'd1;
        end else if (jump_rise) begin
          air_nx  = 1'b1;
          jtmr_nx = JUMP_LEN - 8'd1;
        end
        if (clear && score != 8'hff)
          score_nx = score + 8'd1;
        if (hit_cond)
          lives_nx = lives - 3'd1;
        // A fatal hit outranks a win landing on the same cycle
        if (hit_cond && lives == 3'd1) begin
          state_nx = S_LOST;
          htmr_nx  = END_HOLD - 8'd1;
          air_nx   = 1'b0;
          jtmr_nx  = 8'd0;
        end else if (win) begin
          state_nx = S_WON;
          htmr_nx  = END_HOLD - 8'd1;
          air_nx   = 1'b0;
          jtmr_nx  = 8'd0;
        end
      end
      S_WON, S_LOST: begin
        air_nx = 1'b0;
        if (start_rise || htmr == 8'd0)
          state_nx = S_MENU;
        else
          htmr_nx = htmr - 8'd1;
      end
      default: state_nx = S_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_MENU;
      start_q         <= 1'b0;
      jump_q          <= 1'b0;
      jtmr            <= 8'd0;
      htmr            <= 8'd0;
      airborne        <= 1'b0;
      lives           <= 3'(LIVES);
      score           <= 8'd0;
      hit             <= 1'b0;
      reset_obj_count <= 1'b0;
      menuScreen      <= 1'b1;
      playerWon       <= 1'b0;
      playerLost      <= 1'b0;
    end else begin
      state           <= state_nx;
      start_q         <= start_btn;
      jump_q          <= jump_btn;
      jtmr            <= jtmr_nx;
      htmr            <= htmr_nx;
      airborne        <= air_nx;
      lives           <= lives_nx;
      score           <= score_nx;
      hit             <= hit_nx;
      reset_obj_count <= hit_nx;
      menuScreen      <= (state_nx == S_MENU);
      playerWon       <= (state_nx == S_WON);
      playerLost      <= (state_nx == S_LOST);
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios then random play,
// all checked against a rule-level model of the game flow.
module tb_game_state_ctrl;

  localparam int WIN_T  = 1800;
  localparam int NLIVES = 3;
  localparam int OSTART = 680;
  localparam int XLO    = 80;
  localparam int XHI    = 120;
  localparam int JLEN   = 40;
  localparam int HOLD   = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        jump_btn;
  logic [9:0]  obj_position_counter;
  logic [10:0] game_time;
  logic        menuScreen, playerWon, playerLost;
  logic        reset_obj_count, hit, airborne;
  logic [2:0]  lives;
  logic [7:0]  score;

  game_state_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .start_btn            (start_btn),
    .jump_btn             (jump_btn),
    .obj_position_counter (obj_position_counter),
    .game_time            (game_time),
    .menuScreen           (menuScreen),
    .playerWon            (playerWon),
    .playerLost           (playerLost),
    .reset_obj_count      (reset_obj_count),
    .hit                  (hit),
    .airborne             (airborne),
    .lives                (lives),
    .score                (score)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  string phase = "init";

  // Model: 0 menu, 1 play, 2 won, 3 lost
  int m_mode, m_lives, m_score, m_air_left, m_hold;
  bit m_prev_s, m_prev_j, m_pulse;

  task automatic model_reset();
    m_mode = 0; m_lives = NLIVES; m_score = 0;
    m_air_left = 0; m_hold = 0;
    m_prev_s = 0; m_prev_j = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit s, input bit j,
                            input int c, input int g);
    bit sr, jr, hc;
    sr = s && !m_prev_s;
    jr = j && !m_prev_j;
    case (m_mode)
      0: begin
        m_pulse = 0;
        if (sr) begin
          m_mode = 1; m_lives = NLIVES;
          m_score = 0; m_air_left = 0;
        end
      end
      1: begin
        hc = (c <= OSTART) && (OSTART - c >= XLO) &&
             (OSTART - c <= XHI) && m_air_left == 0 && !m_pulse;
        if (m_air_left > 0) m_air_left--;
        else if (jr) m_air_left = JLEN;
        if (c >= OSTART && m_score < 255) m_score++;
        m_pulse = hc;
        if (hc) m_lives--;
        if (hc && m_lives == 0) begin
          m_mode = 3; m_hold = 0; m_air_left = 0;
        end else if (g >= WIN_T) begin
          m_mode = 2; m_hold = 0; m_air_left = 0;
        end
      end
      default: begin
        m_pulse = 0;
        m_hold++;
        if (sr || m_hold == HOLD) m_mode = 0;
      end
    endcase
    m_prev_s = s;
    m_prev_j = j;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s/%s observed=%0d expected=%0d",
                phase, tag, obs, exp);
  endtask

  task automatic check_all();
    chk("menuScreen", 32'(menuScreen), 32'(m_mode == 0));
    chk("playerWon",  32'(playerWon),  32'(m_mode == 2));
    chk("playerLost", 32'(playerLost), 32'(m_mode == 3));
    chk("reset_obj",  32'(reset_obj_count), 32'(m_pulse));
    chk("hit",        32'(hit),        32'(m_pulse));
    chk("airborne",   32'(airborne),   32'(m_air_left > 0));
    chk("lives",      32'(lives),      32'(m_lives));
    chk("score",      32'(score),      32'(m_score));
  endtask

  task automatic step(input bit s, input bit j,
                      input int c, input int g);
    start_btn = s;
    jump_btn = j;
    obj_position_counter = 10'(c);
    game_time = 11'(g);
    @(posedge clk);
    #1;
    model_step(s, j, c, g);
    check_all();
  endtask

  initial begin
    int air_cnt, c, g, r;
    bit s, j;
    reset = 1'b1;
    start_btn = 0; jump_btn = 0;
    obj_position_counter = '0; game_time = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check_all();
    #2 reset = 1'b0;

    phase = "t1_start";
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("menu_off", 32'(menuScreen), 0);
    chk("lives3", 32'(lives), 3);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    phase = "t2_hit";
    step(0, 0, 560, 0);
    chk("hit_pulse", 32'(hit), 1);
    chk("lives2", 32'(lives), 2);
    step(0, 0, 560, 0);
    chk("no_rehit", 32'(hit), 0);
    step(0, 0, 0, 0);

    phase = "t3_jump";
    air_cnt = 0;
    step(0, 1, 0, 0);
    air_cnt += 32'(airborne);
    for (int i = 0; i < 50; i++) begin
      j = (i == 10 || i == 11);
      c = (i < 40) ? 540 + 2 * i : 0;
      step(0, j, c, 0);
      air_cnt += 32'(airborne);
    end
    chk("air_len", 32'(air_cnt), JLEN);
    chk("lives_kept", 32'(lives), 2);

    phase = "t4_score";
    step(0, 0, 680, 0);
    chk("score1", 32'(score), 1);
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 680, 0);
      step(0, 0, 0, 0);
    end
    chk("score_sat", 32'(score), 255);

    phase = "t5_lost";
    step(0, 0, 560, 0);
    step(0, 0, 0, 0);
    chk("lives1", 32'(lives), 1);
    step(0, 0, 560, WIN_T);
    chk("lost", 32'(playerLost), 1);
    chk("not_won", 32'(playerWon), 0);
    chk("lives0", 32'(lives), 0);
    for (int i = 0; i < HOLD - 1; i++) step(0, 0, 0, 0);
    chk("still_lost", 32'(playerLost), 1);
    step(0, 0, 0, 0);
    chk("back_menu", 32'(menuScreen), 1);

    phase = "t6_won";
    step(1, 0, 0, 0);
    step(0, 0, 0, WIN_T);
    chk("won", 32'(playerWon), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("start_exit", 32'(menuScreen), 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 680, 0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    phase = "t6_async_reset";
    check_all();
    @(posedge clk);
    #2 reset = 1'b0;

    phase = "random";
    s = 0; j = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) s = ~s;
      if ($urandom_range(0, 3) == 0) j = ~j;
      r = $urandom_range(0, 99);
      if (r < 40)      c = $urandom_range(0, 1023);
      else if (r < 70) c = $urandom_range(540, 610);
      else if (r < 85) c = OSTART;
      else             c = 0;
      if ($urandom_range(0, 39) == 0) g = $urandom_range(WIN_T, 2047);
      else g = $urandom_range(0, WIN_T - 1);
      step(s, j, c, g);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
